// File: rtl/rd53_sync_fe_pkg.sv
// Shared types and constants for the RD53A synchronous front-end
// auto-zero sequencer: FSM state encoding and default widths.
package rd53_sync_fe_pkg;

  localparam int PER_W_DEF    = 16;
  localparam int TIM_W_DEF    = 8;
  localparam int AZ_MIN_WIDTH = 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    AZ,
    SETTLE
  } az_state_t;

endpackage

// File: rtl/rd53_az_timer.sv
// Loadable down-counter used for the auto-zero width and settle phases.
// Ports: clk, rst_n, load/load_val (reload), en (count), done (cnt<=1).
module rd53_az_timer #(
  parameter int TIM_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [TIM_W-1:0] load_val,
  input  logic             en,
  output logic             done
);

  logic [TIM_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - TIM_W'(1);
    end
  end

  // The phase ends on the cycle that sees the last count.
  assign done = (cnt <= TIM_W'(1));

endmodule

// File: rtl/rd53_sync_fe_az_ctrl.sv
// RD53A synchronous FE sequencer: PHI_AZ_TO, STROBE_TO blanking and
// S0/S1 injection gating. Inputs: EN, AZ_* config, AZ_REQ, INJ_*.
module rd53_sync_fe_az_ctrl
  import rd53_sync_fe_pkg::*;
#(
  parameter int PER_W = PER_W_DEF,
  parameter int TIM_W = TIM_W_DEF
) (
  input  logic             CLK,
  input  logic             RST_B,
  input  logic             EN,
  input  logic             AZ_MODE,
  input  logic [PER_W-1:0] AZ_PERIOD,
  input  logic [TIM_W-1:0] AZ_WIDTH,
  input  logic [TIM_W-1:0] AZ_SETTLE,
  input  logic             AZ_REQ,
  input  logic             INJ_REQ,
  input  logic [1:0]       INJ_SEL,
  output logic             INJ_ACK,
  output logic             PHI_AZ_TO,
  output logic             STROBE_TO,
  output logic             S0,
  output logic             S1,
  output logic             BLANK,
  output logic [PER_W-1:0] AZ_COUNT
);

  az_state_t state, state_nx;

  logic [PER_W-1:0] per_cnt;
  logic             per_hit;
  logic             az_start;
  logic [TIM_W-1:0] wid_val;
  logic             wid_en, wid_done;
  logic             set_en, set_done;
  logic             az_exit, az_exit_q;
  logic             inj_block;
  logic             inj_fire, inj_fire_q;
  logic [1:0]       inj_sel_q;
  logic             phi_d, strobe_d, blank_d, ack_d;
  logic [1:0]       sel_d;

  assign per_hit = (AZ_PERIOD != '0) &&
                   (per_cnt == AZ_PERIOD - PER_W'(1));

  assign az_start = EN && (state == RUN) &&
                    (AZ_MODE ? AZ_REQ : per_hit);

  assign wid_val = (AZ_WIDTH < TIM_W'(AZ_MIN_WIDTH)) ?
                   TIM_W'(AZ_MIN_WIDTH) : AZ_WIDTH;

  assign wid_en  = (state == AZ);
  assign set_en  = (state == SETTLE);
  assign az_exit = EN && (state == AZ) && wid_done;

  // Auto-zero has priority; a held request fires once RUN is free.
  assign inj_fire = EN && (state == RUN) && INJ_REQ &&
                    !inj_block && !az_start;

  rd53_az_timer #(.TIM_W(TIM_W)) u_wid (
    .clk      (CLK),
    .rst_n    (RST_B),
    .load     (az_start),
    .load_val (wid_val),
    .en       (wid_en),
    .done     (wid_done)
  );

  rd53_az_timer #(.TIM_W(TIM_W)) u_set (
    .clk      (CLK),
    .rst_n    (RST_B),
    .load     (az_exit),
    .load_val (AZ_SETTLE),
    .en       (set_en),
    .done     (set_done)
  );

  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (!EN) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE:   state_nx = RUN;
        RUN:    if (az_start) state_nx = AZ;
        AZ: begin
          if (wid_done) begin
            state_nx = (AZ_SETTLE == '0) ? RUN : SETTLE;
          end
        end
        SETTLE: if (set_done) state_nx = RUN;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    phi_d    = 1'b0;
    strobe_d = 1'b0;
    blank_d  = 1'b0;
    if (EN) begin
      unique case (state)
        RUN: strobe_d = 1'b1;
        AZ: begin
          phi_d   = 1'b1;
          blank_d = 1'b1;
        end
        SETTLE: blank_d = 1'b1;
        default: ;
      endcase
    end
    ack_d = EN && inj_fire_q;
    sel_d = ack_d ? inj_sel_q : 2'b00;
  end

  // Period counter runs only in RUN and is zero on every RUN entry.
  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      per_cnt <= '0;
    end else if (!EN || (state != RUN) || az_start) begin
      per_cnt <= '0;
    end else begin
      per_cnt <= per_cnt + PER_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      inj_block  <= 1'b0;
      inj_fire_q <= 1'b0;
      inj_sel_q  <= 2'b00;
      az_exit_q  <= 1'b0;
    end else begin
      if (inj_fire) begin
        inj_block <= 1'b1;
        inj_sel_q <= INJ_SEL;
      end else if (!INJ_REQ) begin
        inj_block <= 1'b0;
      end
      inj_fire_q <= inj_fire;
      az_exit_q  <= az_exit;
    end
  end

  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      PHI_AZ_TO <= 1'b0;
      STROBE_TO <= 1'b0;
      BLANK     <= 1'b0;
      INJ_ACK   <= 1'b0;
      S0        <= 1'b0;
      S1        <= 1'b0;
      AZ_COUNT  <= '0;
    end else begin
      PHI_AZ_TO <= phi_d;
      STROBE_TO <= strobe_d;
      BLANK     <= blank_d;
      INJ_ACK   <= ack_d;
      S0        <= sel_d[0];
      S1        <= sel_d[1];
      if (az_exit_q && (AZ_COUNT != '1)) begin
        AZ_COUNT <= AZ_COUNT + PER_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_rd53_sync_fe_az_ctrl.sv
// Bench for rd53_sync_fe_az_ctrl: timeline reference model feeding a
// scoreboard, directed scenarios plus randomized traffic.
module tb_rd53_sync_fe_az_ctrl;

  localparam int PW = 16;
  localparam int TW = 8;

  logic          clk = 1'b0;
  logic          rst_b = 1'b1;
  logic          en = 1'b0;
  logic          az_mode = 1'b0;
  logic [PW-1:0] az_period = '0;
  logic [TW-1:0] az_width = '0;
  logic [TW-1:0] az_settle = '0;
  logic          az_req = 1'b0;
  logic          inj_req = 1'b0;
  logic [1:0]    inj_sel = 2'b00;
  logic          ack, phi, strobe, s0, s1, blank;
  logic [PW-1:0] az_count;

  rd53_sync_fe_az_ctrl #(.PER_W(PW), .TIM_W(TW)) dut (
    .CLK       (clk),
    .RST_B     (rst_b),
    .EN        (en),
    .AZ_MODE   (az_mode),
    .AZ_PERIOD (az_period),
    .AZ_WIDTH  (az_width),
    .AZ_SETTLE (az_settle),
    .AZ_REQ    (az_req),
    .INJ_REQ   (inj_req),
    .INJ_SEL   (inj_sel),
    .INJ_ACK   (ack),
    .PHI_AZ_TO (phi),
    .STROBE_TO (strobe),
    .S0        (s0),
    .S1        (s1),
    .BLANK     (blank),
    .AZ_COUNT  (az_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          phi;
    logic          stb;
    logic          blk;
    logic          ack;
    logic          s1;
    logic          s0;
    logic [PW-1:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;

  // Reference timeline: mode 0 idle, 1 running, 2 auto-zero window
  // (edges k .. k+W+S-1 at the control level; outputs lag by one edge).
  int            n_m, mode_m, k_m, w_m, s_m;
  logic [PW-1:0] p_m, cnt_m;
  bit            armed_m, fire_m, exit_m;
  logic [1:0]    sel_m;

  logic [63:0] lp, ls, lb, la, l1, l0;
  logic [PW-1:0] lc [64];

  task automatic model_reset();
    n_m = 0; mode_m = 0; k_m = -1000; w_m = 1; s_m = 0;
    p_m = '0; cnt_m = '0; armed_m = 1'b1;
    fire_m = 1'b0; exit_m = 1'b0; sel_m = 2'b00;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, act, req);
    end
  endtask

  // Called at a negedge with inputs applied for the coming posedge.
  task automatic tick();
    exp_t e;
    int   prev;
    bit   st, fire;
    prev = mode_m;
    st = 1'b0;
    if (en && prev == 1) begin
      if (az_mode) st = az_req;
      else st = (az_period != '0) && (p_m == az_period - 16'd1);
    end
    if (exit_m && cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'd1;
    e.phi = en && prev == 2 && (n_m <= k_m + w_m);
    e.stb = en && prev == 1;
    e.blk = en && prev == 2;
    e.ack = en && fire_m;
    {e.s1, e.s0} = (en && fire_m) ? sel_m : 2'b00;
    e.cnt = cnt_m;
    exit_m = en && prev == 2 && (n_m == k_m + w_m);
    fire = en && prev == 1 && inj_req && armed_m && !st;
    if (fire) begin
      armed_m = 1'b0;
      sel_m = inj_sel;
    end else if (!inj_req) begin
      armed_m = 1'b1;
    end
    fire_m = fire;
    if (!en) begin
      mode_m = 0;
    end else if (prev == 0) begin
      mode_m = 1; p_m = '0;
    end else if (prev == 1) begin
      if (st) begin
        mode_m = 2; k_m = n_m; p_m = '0;
        w_m = (az_width == '0) ? 1 : int'(az_width);
        s_m = int'(az_settle);
      end else begin
        p_m = p_m + 16'd1;
      end
    end else if (n_m == k_m + w_m + s_m) begin
      mode_m = 1; p_m = '0;
    end
    n_m++;
    sb_q.push_back(e);
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    exp_t e, g;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      g = {phi, strobe, blank, ack, s1, s0, az_count};
      checks++;
      if (g[PW+5:PW] !== e[PW+5:PW]) begin
        failures++;
        $display("FAIL sb_ctl t=%0t phi,stb,blk,ack,s1,s0 got=%b exp=%b",
                 $time, g[PW+5:PW], e[PW+5:PW]);
      end
      checks++;
      if (g.cnt !== e.cnt) begin
        failures++;
        $display("FAIL sb_az_count t=%0t got=%0d exp=%0d",
                 $time, g.cnt, e.cnt);
      end
    end
  end

  task automatic clr_logs();
    lp = '0; ls = '0; lb = '0; la = '0; l1 = '0; l0 = '0;
  endtask

  task automatic log_at(int i);
    lp[i] = phi; ls[i] = strobe; lb[i] = blank;
    la[i] = ack; l1[i] = s1; l0[i] = s0; lc[i] = az_count;
  endtask

  function automatic int first_at(logic [63:0] v, int from, logic val);
    for (int i = from; i < 64; i++) begin
      if (v[i] === val) return i;
    end
    return -1;
  endfunction

  task automatic idle_cycles(int n);
    en = 1'b0; az_req = 1'b0; inj_req = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [PW-1:0] c0;
    bit            got, found;
    model_reset();
    #1 rst_b = 1'b0;
    #1;
    chk("reset_ctl", 32'({phi, strobe, blank, ack, s1, s0}), 0);
    chk("reset_count", 32'(az_count), 0);
    @(negedge clk);
    rst_b = 1'b1;
    model_reset();

    // Periodic auto-zero, EN sampled high at edge 0.
    az_mode = 1'b0; az_period = 16'd10;
    az_width = 8'd3; az_settle = 8'd2;
    idle_cycles(2);
    clr_logs();
    en = 1'b1;
    for (int i = 0; i < 32; i++) begin
      tick(); log_at(i);
    end
    chk("per_phi_rise", first_at(lp, 0, 1'b1), 11);
    chk("per_phi_fall", first_at(lp, 12, 1'b0), 14);
    chk("per_stb_low", first_at(ls, 1, 1'b0), 11);
    chk("per_stb_back", first_at(ls, 12, 1'b1), 16);
    chk("per_phi_next", first_at(lp, 14, 1'b1), 26);
    chk("per_count_13", 32'(lc[13]), 0);
    chk("per_count_14", 32'(lc[14]), 1);

    // Command mode, minimum width, no settle; second request dropped.
    az_mode = 1'b1; az_width = 8'd0; az_settle = 8'd0;
    idle_cycles(2);
    clr_logs();
    en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      az_req = (i == 5 || i == 6);
      tick(); log_at(i);
    end
    az_req = 1'b0;
    chk("cmd_phi_at", first_at(lp, 0, 1'b1), 6);
    chk("cmd_phi_pulses", $countones(lp[15:0]), 1);
    chk("cmd_stb_5", 32'(ls[5]), 1);
    chk("cmd_stb_6", 32'(ls[6]), 0);
    chk("cmd_stb_7", 32'(ls[7]), 1);

    // Injection in RUN, held request, then re-arm via one low cycle.
    clr_logs();
    inj_sel = 2'b10;
    for (int i = 0; i < 16; i++) begin
      inj_req = (i >= 2 && i < 8) || (i >= 9 && i < 12);
      tick(); log_at(i);
    end
    inj_req = 1'b0;
    chk("inj_ack_first", first_at(la, 0, 1'b1), 3);
    chk("inj_ack_second", first_at(la, 4, 1'b1), 10);
    chk("inj_ack_total", $countones(la[15:0]), 2);
    chk("inj_s1", 32'(l1[3]), 1);
    chk("inj_s0", 32'(l0[3]), 0);

    // Injection collides with auto-zero start.
    clr_logs();
    az_width = 8'd4; az_settle = 8'd3; inj_sel = 2'b01;
    got = 1'b0;
    for (int i = 0; i < 24; i++) begin
      az_req = (i == 2);
      inj_req = (i >= 2) && !got;
      tick(); log_at(i);
      if (ack) got = 1'b1;
    end
    inj_req = 1'b0; az_req = 1'b0;
    chk("col_stb_back", first_at(ls, 4, 1'b1), 10);
    chk("col_ack_at", first_at(la, 0, 1'b1), 11);
    chk("col_sel_in_blank", $countones(lb & (l0 | l1)), 0);

    // Abort: EN drops two cycles into a long auto-zero.
    clr_logs();
    az_width = 8'd8;
    c0 = az_count;
    for (int i = 0; i < 8; i++) begin
      az_req = (i == 1);
      en = !(i >= 4 && i < 7);
      tick(); log_at(i);
    end
    az_req = 1'b0; en = 1'b1;
    chk("abort_phi_before", 32'(lp[3]), 1);
    chk("abort_ctl", 32'({lp[4], ls[4], lb[4]}), 0);
    chk("abort_count", 32'(lc[6]), 32'(c0));

    // Asynchronous reset in the middle of SETTLE.
    az_mode = 1'b0; az_period = 16'd5;
    az_width = 8'd2; az_settle = 8'd6;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      tick();
      if (blank && !phi) found = 1'b1;
    end
    chk("rst_found_settle", 32'(found), 1);
    #2 rst_b = 1'b0;
    #1;
    chk("rst_mid_ctl", 32'({phi, strobe, blank, ack, s1, s0}), 0);
    chk("rst_mid_count", 32'(az_count), 0);
    @(negedge clk);
    rst_b = 1'b1;
    model_reset();
    clr_logs();
    for (int i = 0; i < 12; i++) begin
      tick(); log_at(i);
    end
    chk("rst_restart_phi", first_at(lp, 0, 1'b1), 6);

    // Randomized traffic against the reference timeline.
    for (int ph = 0; ph < 24; ph++) begin
      idle_cycles(1);
      az_mode = 1'($urandom_range(0, 1));
      az_width = 8'($urandom_range(0, 5));
      az_settle = 8'($urandom_range(0, 4));
      if ($urandom_range(0, 5) == 0) az_period = '0;
      else az_period = 16'($urandom_range(1, 15));
      for (int c = 0; c < 60; c++) begin
        az_req = ($urandom_range(0, 9) == 0);
        if ($urandom_range(0, 4) == 0) inj_req = ~inj_req;
        inj_sel = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 49) == 0) begin
          az_period = 16'($urandom_range(0, 12));
        end
        en = ($urandom_range(0, 39) != 0);
        tick();
      end
    end

    idle_cycles(1);
    repeat (2) @(negedge clk);
    chk("sb_drain", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rd53_sync_fe_az_ctrl.md
Name: rd53_sync_fe_az_ctrl

Overview:
Sequencer for the RD53A synchronous (TO) analog front end. It generates the auto-zero phase (PHI_AZ_TO) either periodically or on command, and blanks the discriminator latch strobe (STROBE_TO) during auto-zero and its settle window. It also gates calibration injection (S0/S1) so that no charge is injected while the front end is auto-zeroing. It sits between the global configuration/command decoder and the pixel-matrix front-end control lines, and runs on the 40 MHz BX clock.

Parameters:
PER_W, 16, width of the auto-zero period counter and of AZ_COUNT
TIM_W, 8, width of the AZ width and settle counters

Ports:
CLK  in  1  BX clock (40 MHz)
RST_B  in  1  asynchronous active-low reset
EN  in  1  block enable; low forces IDLE
AZ_MODE  in  1  0 = periodic auto-zero, 1 = auto-zero on AZ_REQ only
AZ_PERIOD  in  PER_W  RUN cycles between auto-zeros; 0 disables periodic mode
AZ_WIDTH  in  TIM_W  PHI_AZ_TO high time in cycles; 0 treated as 1
AZ_SETTLE  in  TIM_W  blanking cycles after PHI_AZ_TO falls; 0 allowed
AZ_REQ  in  1  single-cycle auto-zero request (used when AZ_MODE=1)
INJ_REQ  in  1  injection request level, held until INJ_ACK
INJ_SEL  in  2  {S1,S0} pattern to drive for the injection
INJ_ACK  out  1  one-cycle acknowledge; coincides with the S0/S1 pulse
PHI_AZ_TO  out  1  auto-zero phase to the front end
STROBE_TO  out  1  latch strobe enable
S0  out  1  injection select 0
S1  out  1  injection select 1
BLANK  out  1  high in AZ and SETTLE
AZ_COUNT  out  PER_W  completed auto-zeros, saturating

Behaviour:
- All outputs are registered. On reset: state IDLE; all outputs and counters are 0.
- States: IDLE, RUN, AZ, SETTLE. In any state, EN=0 moves to IDLE at the next edge, clears every output except AZ_COUNT, and aborts any AZ in progress.
- IDLE -> RUN when EN=1. The period counter is cleared.
- RUN:
  - STROBE_TO=1. The period counter increments each cycle.
  - az_start = (AZ_MODE=0 and AZ_PERIOD!=0 and cnt==AZ_PERIOD-1) or (AZ_MODE=1 and AZ_REQ).
  - On az_start: go to AZ, load the width counter with max(AZ_WIDTH,1), clear the period counter.
- Timing for az_start sampled at edge k:
  - PHI_AZ_TO=1 and STROBE_TO=0 from edge k+1 through edge k+W.
  - PHI_AZ_TO=0 at edge k+W+1.
  - STROBE_TO returns to 1 at edge k+W+S+1, where W=max(AZ_WIDTH,1) and S=AZ_SETTLE.
- AZ: PHI_AZ_TO=1, BLANK=1. The width counter decrements each cycle; at 1, go to SETTLE, or go directly to RUN if AZ_SETTLE=0.
- SETTLE: PHI_AZ_TO=0, BLANK=1, STROBE_TO=0. Count AZ_SETTLE cycles, then go to RUN with the period counter at 0.
- AZ_COUNT increments on the AZ exit edge and saturates at all-ones. It is not cleared by EN, only by reset.
- AZ_REQ arriving in AZ or SETTLE is dropped; requests do not queue. AZ_REQ is ignored when AZ_MODE=0.
- AZ_PERIOD, AZ_WIDTH and AZ_SETTLE are sampled when used:
  - width and settle are sampled at counter load;
  - period is compared live.
  - If AZ_PERIOD is lowered below the current count, the counter wraps at 2^PER_W.
- Injection:
  - An armed injection fires when INJ_REQ=1 in RUN and az_start is not asserted that cycle.
  - At the next edge, S0/S1 = INJ_SEL and INJ_ACK=1 for exactly one cycle. STROBE_TO stays 1.
  - After firing, the injection is disarmed until INJ_REQ is sampled low.
  - INJ_REQ in IDLE, AZ or SETTLE is held pending and fires on the first eligible RUN cycle.
  - If az_start and INJ_REQ occur together, auto-zero wins and the injection is deferred.
  - If EN drops while an injection is pending, no ACK is issued.

Decomposition:
- Package rd53_sync_fe_pkg holds:
  - enum az_state_t {IDLE, RUN, AZ, SETTLE};
  - PER_W and TIM_W default constants;
  - localparam AZ_MIN_WIDTH = 1.
- One sub-module, rd53_az_timer: a loadable TIM_W down-counter with load, enable and done, instantiated twice (width and settle).

Test Plan:
- Periodic, AZ_MODE=0, PERIOD=10, WIDTH=3, SETTLE=2, EN rises at edge 0:
  - PHI_AZ_TO high at edges 11-13; STROBE_TO low at edges 11-15;
  - next PHI_AZ_TO rise at edge 26;
  - AZ_COUNT = 1 after edge 14.
- Command mode, AZ_MODE=1, WIDTH=0, SETTLE=0:
  - AZ_REQ at edge 5 gives a 1-cycle PHI_AZ_TO at edge 6 and STROBE_TO low at edge 6 only;
  - a second AZ_REQ at edge 6 is dropped, so there is no second pulse.
- Injection in RUN: INJ_REQ=1, INJ_SEL=2'b10 gives S1=1, S0=0 and INJ_ACK for exactly one cycle. Holding INJ_REQ high causes no re-fire; re-fire happens only after INJ_REQ low for one cycle.
- Injection collision:
  - INJ_REQ rises on the same edge as az_start (WIDTH=4, SETTLE=3);
  - INJ_ACK must occur exactly one cycle after STROBE_TO returns high;
  - S0/S1 stay 0 throughout BLANK.
- Abort: EN drops 2 cycles into AZ with WIDTH=8. PHI_AZ_TO, STROBE_TO and BLANK are 0 at the next edge, and AZ_COUNT is unchanged.
- Reset mid-SETTLE: RST_B low asynchronously clears all outputs immediately. After release with EN=1, RUN is entered and the period counter restarts from 0.
